// File: rtl/floo_eject_sink.sv
// floo_eject_sink: terminator for unused router eject ports.
// Each channel absorbs flits through a valid/ready link and drops them. The
// ready line can be throttled so that it rises once every ReadyPeriod cycles.
// For status, each channel keeps a saturating flit count, the payload of the
// last accepted flit, a sticky "seen" flag and a sticky stall-timeout flag.
module floo_eject_sink #(
  parameter int unsigned NumChannels   = 3,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned CntWidth      = 16,
  parameter int unsigned ReadyPeriod   = 1,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             enable_i,
  input  logic                             clear_i,
  input  logic [NumChannels-1:0]           valid_i,
  output logic [NumChannels-1:0]           ready_o,
  input  logic [NumChannels*DataWidth-1:0] data_i,
  output logic [NumChannels*CntWidth-1:0]  flit_cnt_o,
  output logic [NumChannels*DataWidth-1:0] last_data_o,
  output logic [NumChannels-1:0]           seen_o,
  output logic [NumChannels-1:0]           timeout_o
);

  // The phase must hold values 0..ReadyPeriod-1.
  // The stall counter must be able to reach TimeoutCycles.
  localparam int unsigned PhaseWidth = (ReadyPeriod > 1) ? $clog2(ReadyPeriod) : 1;
  localparam int unsigned StallWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [PhaseWidth-1:0] PhaseLast  = PhaseWidth'(ReadyPeriod - 1);
  localparam logic [PhaseWidth-1:0] PhaseOne   = (ReadyPeriod > 1) ? PhaseWidth'(1) : '0;
  localparam logic [StallWidth-1:0] StallLimit = StallWidth'(TimeoutCycles);
  localparam logic [StallWidth-1:0] StallOne   = StallWidth'(1);

  typedef enum logic [1:0] {
    Idle    = 2'd0,
    Stall   = 2'd1,
    Timeout = 2'd2
  } state_e;

  for (genvar gi = 0; gi < NumChannels; gi++) begin : gen_ch
    logic [PhaseWidth-1:0] phase_q, phase_d;
    logic [CntWidth-1:0]   cnt_q;
    logic [DataWidth-1:0]  last_q;
    logic                  seen_q;
    logic                  timeout_q;
    state_e                state_q;
    logic [StallWidth-1:0] stall_q;
    logic                  ready;
    logic                  hs;
    logic                  stalled;

    // Ready depends only on the phase and the global enable. It never looks at valid.
    assign ready   = enable_i & (phase_q == '0);
    assign hs      = valid_i[gi] & ready;
    assign stalled = valid_i[gi] & ~ready;

    // Phase sequencing.
    // At phase 0, the phase waits for a flit. After a flit, it runs through the
    // rest of the period. While disabled, it is held at 0.
    always_comb begin
      phase_d = phase_q;
      if (!enable_i) begin
        phase_d = '0;
      end else if (phase_q == '0) begin
        if (hs) phase_d = PhaseOne;
      end else if (phase_q == PhaseLast) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + PhaseWidth'(1);
      end
    end

    // Phase register. Clear does not touch it, so throttling continues across a clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) phase_q <= '0;
      else       phase_q <= phase_d;
    end

    // Saturating flit counter and sticky seen flag.
    // If clear and a handshake happen together, clear wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_q  <= '0;
        seen_q <= 1'b0;
      end else if (clear_i) begin
        cnt_q  <= '0;
        seen_q <= 1'b0;
      end else if (hs) begin
        if (cnt_q != '1) cnt_q <= cnt_q + CntWidth'(1);
        seen_q <= 1'b1;
      end
    end

    // Capture the payload of every accepted flit. Clear does not erase it.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)   last_q <= '0;
      else if (hs) last_q <= data_i[gi*DataWidth +: DataWidth];
    end

    // Stall watchdog FSM.
    // It counts consecutive cycles with valid high and ready low.
    // The timeout flag is registered and stays set until a clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q   <= Idle;
        stall_q   <= '0;
        timeout_q <= 1'b0;
      end else if (clear_i) begin
        state_q   <= Idle;
        stall_q   <= '0;
        timeout_q <= 1'b0;
      end else if (TimeoutCycles != 0) begin
        unique case (state_q)
          Idle: begin
            if (stalled) begin
              if (StallLimit <= StallOne) begin
                state_q   <= Timeout;
                timeout_q <= 1'b1;
                stall_q   <= '0;
              end else begin
                state_q <= Stall;
                stall_q <= StallOne;
              end
            end
          end
          Stall: begin
            if (stalled) begin
              if (stall_q + StallOne == StallLimit) begin
                state_q   <= Timeout;
                timeout_q <= 1'b1;
                stall_q   <= '0;
              end else begin
                stall_q <= stall_q + StallOne;
              end
            end else begin
              state_q <= Idle;
              stall_q <= '0;
            end
          end
          Timeout: state_q <= Timeout;
          default: begin
            state_q <= Idle;
            stall_q <= '0;
          end
        endcase
      end
    end

    assign ready_o[gi]                              = ready;
    assign flit_cnt_o[gi*CntWidth +: CntWidth]      = cnt_q;
    assign last_data_o[gi*DataWidth +: DataWidth]   = last_q;
    assign seen_o[gi]                               = seen_q;
    assign timeout_o[gi]                            = timeout_q;
  end

endmodule

// File: tb/tb_floo_eject_sink.sv
// Testbench for floo_eject_sink.
// Two instances share one stimulus stream. Instance A uses CntWidth=3 and
// ReadyPeriod=1. Instance B uses CntWidth=16 and ReadyPeriod=3. Both use
// TimeoutCycles=4. A reference model of the behaviour advances once per clock.
module tb_floo_eject_sink;
  localparam int NC  = 3;
  localparam int DW  = 16;
  localparam int CWA = 3;
  localparam int RPA = 1;
  localparam int CWB = 16;
  localparam int RPB = 3;
  localparam int TOC = 4;

  logic clk = 1'b0;
  logic rst, enable, clear;
  logic [NC-1:0]     valid;
  logic [NC*DW-1:0]  data;
  logic [NC-1:0]     ready_a, seen_a, to_a, ready_b, seen_b, to_b;
  logic [NC*CWA-1:0] cnt_a;
  logic [NC*CWB-1:0] cnt_b;
  logic [NC*DW-1:0]  last_a, last_b;

  int compared = 0;
  int mismatched = 0;

  // Reference model state, indexed as [instance][channel].
  int          m_phase[2][NC];
  int          m_cnt[2][NC];
  logic [DW-1:0] m_last[2][NC];
  bit          m_seen[2][NC];
  bit          m_to[2][NC];
  int          m_run[2][NC];

  always #5 clk = ~clk;

  floo_eject_sink #(.NumChannels(NC), .DataWidth(DW), .CntWidth(CWA),
                    .ReadyPeriod(RPA), .TimeoutCycles(TOC)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
    .valid_i(valid), .ready_o(ready_a), .data_i(data), .flit_cnt_o(cnt_a),
    .last_data_o(last_a), .seen_o(seen_a), .timeout_o(to_a));

  floo_eject_sink #(.NumChannels(NC), .DataWidth(DW), .CntWidth(CWB),
                    .ReadyPeriod(RPB), .TimeoutCycles(TOC)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
    .valid_i(valid), .ready_o(ready_b), .data_i(data), .flit_cnt_o(cnt_b),
    .last_data_o(last_b), .seen_o(seen_b), .timeout_o(to_b));

  function automatic int rp(int i);   return (i == 0) ? RPA : RPB; endfunction
  function automatic int cmax(int i); return (i == 0) ? (1 << CWA) - 1 : (1 << CWB) - 1; endfunction
  function automatic logic m_ready(int i, int c); return enable && (m_phase[i][c] == 0); endfunction

  function automatic int dut_cnt(int i, int c);
    return (i == 0) ? int'(cnt_a[c*CWA +: CWA]) : int'(cnt_b[c*CWB +: CWB]);
  endfunction
  function automatic logic [DW-1:0] dut_last(int i, int c);
    return (i == 0) ? last_a[c*DW +: DW] : last_b[c*DW +: DW];
  endfunction
  function automatic logic dut_seen(int i, int c);  return (i == 0) ? seen_a[c]  : seen_b[c];  endfunction
  function automatic logic dut_to(int i, int c);    return (i == 0) ? to_a[c]    : to_b[c];    endfunction
  function automatic logic dut_ready(int i, int c); return (i == 0) ? ready_a[c] : ready_b[c]; endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < NC; c++) begin
        m_phase[i][c] = 0; m_cnt[i][c] = 0; m_last[i][c] = '0;
        m_seen[i][c] = 0;  m_to[i][c] = 0;  m_run[i][c] = 0;
      end
  endtask

  // Advance one clock. The model consumes the inputs that are present at the
  // edge. The task returns 1 time unit after the edge.
  task automatic cycle();
    bit rdy, hs, st;
    @(posedge clk);
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < NC; c++) begin
        rdy = m_ready(i, c);
        hs  = valid[c] && rdy;
        st  = valid[c] && !rdy;
        if (!enable)                m_phase[i][c] = 0;
        else if (m_phase[i][c] == 0) m_phase[i][c] = hs ? (1 % rp(i)) : 0;
        else                        m_phase[i][c] = (m_phase[i][c] + 1) % rp(i);
        if (hs) m_last[i][c] = data[c*DW +: DW];
        if (clear) begin
          m_cnt[i][c] = 0; m_seen[i][c] = 0; m_to[i][c] = 0; m_run[i][c] = 0;
        end else begin
          if (hs) begin
            if (m_cnt[i][c] < cmax(i)) m_cnt[i][c]++;
            m_seen[i][c] = 1;
          end
          if (!m_to[i][c]) begin
            if (st) begin
              m_run[i][c]++;
              if (m_run[i][c] >= TOC) begin m_to[i][c] = 1; m_run[i][c] = 0; end
            end else m_run[i][c] = 0;
          end
        end
      end
    #1;
  endtask

  // Clear the status registers, then wait idle cycles so every phase returns to 0.
  task automatic settle();
    valid = '0; enable = 1'b1; clear = 1'b1;
    cycle();
    clear = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; clear = 1'b0; valid = '0; data = '0;
    model_reset();
    #2;
    compared++;
    if ({cnt_a, cnt_b, last_a, last_b, seen_a, seen_b, to_a, to_b} !== '0) begin
      mismatched++; $display("FAIL reset_state: got cnt_a=%h cnt_b=%h seen=%b/%b to=%b/%b expected all 0",
                             cnt_a, cnt_b, seen_a, seen_b, to_a, to_b);
    end
    compared++;
    if ({ready_a, ready_b} !== 6'b111111) begin
      mismatched++; $display("FAIL reset_ready: got %b/%b expected 111/111", ready_a, ready_b);
    end
    @(negedge clk); rst = 1'b0;
    #1;
    $display("reset: ready_a=%b ready_b=%b", ready_a, ready_b);
  endtask

  task automatic test_back_to_back();
    valid = 3'b001;
    for (int k = 0; k < 5; k++) begin
      data = '0; data[DW-1:0] = DW'(16'h10 + k);
      cycle();
      $display("b2b: flit %0h sent, cnt_a0=%0d", 16'h10 + k, dut_cnt(0, 0));
    end
    valid = '0;
    compared++;
    if (dut_cnt(0, 0) !== 5 || dut_last(0, 0) !== 16'h14 || seen_a !== 3'b001) begin
      mismatched++; $display("FAIL b2b_a: got cnt=%0d last=%h seen=%b expected 5 0014 001",
                             dut_cnt(0, 0), dut_last(0, 0), seen_a);
    end
    compared++;
    if (dut_cnt(0, 1) !== 0 || dut_cnt(0, 2) !== 0) begin
      mismatched++; $display("FAIL b2b_others: got %0d %0d expected 0 0", dut_cnt(0, 1), dut_cnt(0, 2));
    end
    compared++;
    if (dut_cnt(1, 0) !== m_cnt[1][0] || dut_last(1, 0) !== m_last[1][0]) begin
      mismatched++; $display("FAIL b2b_b: got cnt=%0d last=%h expected %0d %h",
                             dut_cnt(1, 0), dut_last(1, 0), m_cnt[1][0], m_last[1][0]);
    end
  endtask

  task automatic test_ready_period();
    settle();
    valid = 3'b010;
    for (int k = 0; k < 9; k++) begin
      data = DW*NC'($urandom);
      #1;
      compared++;
      if (ready_b[1] !== ((k % 3) == 0)) begin
        mismatched++; $display("FAIL ready_period k=%0d: got %b expected %b", k, ready_b[1], (k % 3) == 0);
      end
      cycle();
      $display("ready_period: k=%0d cnt_b1=%0d", k, dut_cnt(1, 1));
    end
    valid = '0;
    compared++;
    if (dut_cnt(1, 1) !== 3) begin
      mismatched++; $display("FAIL ready_period_cnt: got %0d expected 3", dut_cnt(1, 1));
    end
  endtask

  task automatic test_timeout();
    settle();
    enable = 1'b0; valid = 3'b100;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      $display("timeout: stall cycle %0d to_a=%b to_b=%b", k, to_a, to_b);
      compared++;
      if (to_a[2] !== (k >= 4) || to_b[2] !== (k >= 4) || to_a[1:0] !== 2'b00) begin
        mismatched++; $display("FAIL timeout_rise k=%0d: got %b/%b expected %b on ch2",
                               k, to_a, to_b, k >= 4);
      end
    end
    enable = 1'b1; valid = '0;
    repeat (2) cycle();
    compared++;
    if (to_a[2] !== 1'b1 || to_b[2] !== 1'b1) begin
      mismatched++; $display("FAIL timeout_sticky: got %b/%b expected 1", to_a[2], to_b[2]);
    end
    clear = 1'b1; cycle(); clear = 1'b0;
    compared++;
    if (to_a !== 3'b000 || to_b !== 3'b000) begin
      mismatched++; $display("FAIL timeout_clear: got %b/%b expected 000", to_a, to_b);
    end
  endtask

  task automatic test_saturate();
    settle();
    valid = 3'b010;
    for (int k = 0; k < 10; k++) begin
      data = DW*NC'($urandom);
      cycle();
      $display("saturate: flit %0d cnt_a1=%0d", k, dut_cnt(0, 1));
    end
    valid = '0;
    compared++;
    if (dut_cnt(0, 1) !== 7 || dut_last(0, 1) !== m_last[0][1]) begin
      mismatched++; $display("FAIL saturate_a: got cnt=%0d last=%h expected 7 %h",
                             dut_cnt(0, 1), dut_last(0, 1), m_last[0][1]);
    end
    compared++;
    if (dut_cnt(1, 1) !== 4) begin
      mismatched++; $display("FAIL saturate_b: got %0d expected 4", dut_cnt(1, 1));
    end
  endtask

  task automatic test_clear_handshake();
    settle();
    valid = 3'b001; data = '0; data[DW-1:0] = DW'(16'h55);
    cycle();
    compared++;
    if (dut_cnt(0, 0) !== 1 || seen_a[0] !== 1'b1) begin
      mismatched++; $display("FAIL clear_hs_pre: got cnt=%0d seen=%b expected 1 1", dut_cnt(0, 0), seen_a[0]);
    end
    data[DW-1:0] = DW'(16'hAB); clear = 1'b1;
    cycle();
    clear = 1'b0; valid = '0;
    $display("clear_hs: cnt_a0=%0d seen_a0=%b last_a0=%h", dut_cnt(0, 0), seen_a[0], dut_last(0, 0));
    compared++;
    if (dut_cnt(0, 0) !== 0 || seen_a[0] !== 1'b0 || dut_last(0, 0) !== 16'hAB) begin
      mismatched++; $display("FAIL clear_hs: got cnt=%0d seen=%b last=%h expected 0 0 00ab",
                             dut_cnt(0, 0), seen_a[0], dut_last(0, 0));
    end
    compared++;
    if (dut_last(1, 0) !== m_last[1][0] || seen_b[0] !== 1'b0) begin
      mismatched++; $display("FAIL clear_hs_b: got last=%h seen=%b expected %h 0",
                             dut_last(1, 0), seen_b[0], m_last[1][0]);
    end
  endtask

  task automatic test_random();
    int errs;
    for (int n = 0; n < 400; n++) begin
      enable = ($urandom_range(0, 7) != 0);
      clear  = ($urandom_range(0, 31) == 0);
      valid  = NC'($urandom);
      data   = DW*NC'({$urandom, $urandom});
      #1;
      errs = 0;
      for (int i = 0; i < 2; i++)
        for (int c = 0; c < NC; c++) begin
          compared++;
          if (dut_ready(i, c) !== m_ready(i, c)) begin
            errs++; mismatched++;
            $display("FAIL rand_ready n=%0d inst%0d ch%0d: got %b expected %b", n, i, c, dut_ready(i, c), m_ready(i, c));
          end
        end
      cycle();
      for (int i = 0; i < 2; i++)
        for (int c = 0; c < NC; c++) begin
          compared++;
          if (dut_cnt(i, c) !== m_cnt[i][c] || dut_last(i, c) !== m_last[i][c] ||
              dut_seen(i, c) !== m_seen[i][c] || dut_to(i, c) !== m_to[i][c]) begin
            errs++; mismatched++;
            $display("FAIL rand_state n=%0d inst%0d ch%0d: got cnt=%0d last=%h seen=%b to=%b expected %0d %h %b %b",
                     n, i, c, dut_cnt(i, c), dut_last(i, c), dut_seen(i, c), dut_to(i, c),
                     m_cnt[i][c], m_last[i][c], m_seen[i][c], m_to[i][c]);
          end
        end
      $display("random: n=%0d en=%b clr=%b valid=%b cnt_a=%h to=%b/%b errs=%0d",
               n, enable, clear, valid, cnt_a, to_a, to_b, errs);
    end
    clear = 1'b0;
  endtask

  task automatic test_async_reset();
    enable = 1'b1; valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      data = DW*NC'({$urandom, $urandom});
      cycle();
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    $display("async_reset: cnt_a=%h seen=%b/%b ready=%b/%b", cnt_a, seen_a, seen_b, ready_a, ready_b);
    compared++;
    if ({cnt_a, cnt_b, last_a, last_b, seen_a, seen_b, to_a, to_b} !== '0) begin
      mismatched++; $display("FAIL async_reset_state: got cnt_a=%h cnt_b=%h seen=%b/%b expected all 0",
                             cnt_a, cnt_b, seen_a, seen_b);
    end
    compared++;
    if ({ready_a, ready_b} !== 6'b111111) begin
      mismatched++; $display("FAIL async_reset_ready: got %b/%b expected 111/111", ready_a, ready_b);
    end
    @(negedge clk); rst = 1'b0; enable = 1'b0;
    #1;
    compared++;
    if ({ready_a, ready_b} !== 6'b000000) begin
      mismatched++; $display("FAIL release_ready_off: got %b/%b expected 000/000", ready_a, ready_b);
    end
    enable = 1'b1;
    #1;
    compared++;
    if ({ready_a, ready_b} !== 6'b111111) begin
      mismatched++; $display("FAIL release_ready_on: got %b/%b expected 111/111", ready_a, ready_b);
    end
    valid = '0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_ready_period();
    test_timeout();
    test_saturate();
    test_clear_handshake();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
